// File: rtl/median_out_stage.sv
// median_out_stage
//   Back end of the 3x3 median filter path. Every pixel shifted into the
//   sorting window produces a median some cycles later. This stage works out
//   which image coordinate each median belongs to (the window centre) and
//   forwards only interior results, in raster order. Border and priming
//   results are discarded.
//
// Parameters
//   WIDTH    image width in pixels  (3..256)
//   HEIGHT   image height in pixels (3..256)
//   SORT_LAT cycles from a window update to its median on med (>= 0)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   pix_valid   a pixel enters the window at this edge
//   med         median from the sorting window
//   out_valid   out_pix/out_row/out_col carry an interior result
//   out_pix     filtered interior pixel
//   out_row     centre row of out_pix    (1..HEIGHT-2)
//   out_col     centre column of out_pix (1..WIDTH-2)
//   frame_done  pulse with the last interior pixel of a frame
//   busy        high while priming or running
module median_out_stage #(
   parameter int WIDTH    = 100,
   parameter int HEIGHT   = 150,
   parameter int SORT_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pix_valid,
   input  logic [7:0] med,
   output logic       out_valid,
   output logic [7:0] out_pix,
   output logic [7:0] out_row,
   output logic [7:0] out_col,
   output logic       frame_done,
   output logic       busy
);

   localparam logic [7:0] COL_MAX  = 8'(WIDTH - 1);
   localparam logic [7:0] ROW_MAX  = 8'(HEIGHT - 1);
   localparam logic [7:0] COL_LAST = 8'(WIDTH - 2);
   localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 2);
   localparam int         STAGES   = SORT_LAT + 1;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   typedef struct packed {
      logic       valid;
      logic       interior;
      logic [7:0] row;
      logic [7:0] col;
      logic       last;
   } tag_t;

   state_t     state_reg, state_next;
   logic [7:0] in_col_reg, in_col_next;
   logic [7:0] in_row_reg, in_row_next;
   logic [7:0] c_col_reg, c_col_next;
   logic [7:0] c_row_reg, c_row_next;
   logic       load_c;
   logic       push;
   logic       prime_done;
   tag_t       tag_in;
   tag_t       tag_out;
   tag_t       stage_reg [0:STAGES-1];
   logic       hit;

   logic       out_valid_reg;
   logic [7:0] out_pix_reg;
   logic [7:0] out_row_reg;
   logic [7:0] out_col_reg;
   logic       frame_done_reg;

   // ---------------------------------------------------------------
   // Input raster counter. Its raster position doubles as the priming
   // count: PRIME only runs straight after IDLE, where the counter
   // restarts at (0,0), so position == pixels accepted so far.
   // ---------------------------------------------------------------
   always_comb begin
      in_col_next = in_col_reg;
      in_row_next = in_row_reg;
      if (pix_valid) begin
         if (in_col_reg == COL_MAX) begin
            in_col_next = 8'd0;
            in_row_next = (in_row_reg == ROW_MAX) ? 8'd0 : in_row_reg + 8'd1;
         end else begin
            in_col_next = in_col_reg + 8'd1;
         end
      end
   end

   // Accepting the pixel at raster position (1,0) brings the count to
   // WIDTH+1: the next pixel completes the window centred on (0,0).
   assign prime_done = pix_valid && (in_row_reg == 8'd1) && (in_col_reg == 8'd0);

   // ---------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      load_c     = 1'b0;
      push       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pix_valid) begin
               state_next = PRIME;
            end
         end
         PRIME: begin
            if (prime_done) begin
               state_next = RUN;
               load_c     = 1'b1;
            end
         end
         RUN: begin
            push = pix_valid;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg == PRIME) || (state_reg == RUN);

   // ---------------------------------------------------------------
   // Centre counter: trails the input counter by WIDTH+1 pixels.
   // ---------------------------------------------------------------
   always_comb begin
      c_col_next = c_col_reg;
      c_row_next = c_row_reg;
      if (load_c) begin
         c_col_next = 8'd0;
         c_row_next = 8'd0;
      end else if (push) begin
         if (c_col_reg == COL_MAX) begin
            c_col_next = 8'd0;
            c_row_next = (c_row_reg == ROW_MAX) ? 8'd0 : c_row_reg + 8'd1;
         end else begin
            c_col_next = c_col_reg + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         in_col_reg <= 8'd0;
         in_row_reg <= 8'd0;
         c_col_reg  <= 8'd0;
         c_row_reg  <= 8'd0;
      end else begin
         state_reg  <= state_next;
         in_col_reg <= in_col_next;
         in_row_reg <= in_row_next;
         c_col_reg  <= c_col_next;
         c_row_reg  <= c_row_next;
      end
   end

   // ---------------------------------------------------------------
   // Tag for the window updated this edge; empty when nothing pushed.
   // ---------------------------------------------------------------
   always_comb begin
      tag_in = '0;
      if (push) begin
         tag_in.valid    = 1'b1;
         tag_in.interior = (c_row_reg >= 8'd1) && (c_row_reg <= ROW_LAST) &&
                           (c_col_reg >= 8'd1) && (c_col_reg <= COL_LAST);
         tag_in.row      = c_row_reg;
         tag_in.col      = c_col_reg;
         tag_in.last     = (c_row_reg == ROW_LAST) && (c_col_reg == COL_LAST);
      end
   end

   // ---------------------------------------------------------------
   // Delay line: shifts every clock so the exiting tag lines up with med.
   // ---------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (rst) begin
               stage_reg[gi] <= '0;
            end else if (gi == 0) begin
               stage_reg[gi] <= tag_in;
            end else begin
               stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
            end
         end
      end
   endgenerate

   assign tag_out = stage_reg[STAGES-1];
   assign hit     = tag_out.valid && tag_out.interior;

   // ---------------------------------------------------------------
   // Output register: data holds its last value between results.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         out_pix_reg    <= 8'd0;
         out_row_reg    <= 8'd0;
         out_col_reg    <= 8'd0;
         frame_done_reg <= 1'b0;
      end else begin
         out_valid_reg  <= hit;
         frame_done_reg <= hit && tag_out.last;
         if (hit) begin
            out_pix_reg <= med;
            out_row_reg <= tag_out.row;
            out_col_reg <= tag_out.col;
         end
      end
   end

   assign out_valid  = out_valid_reg;
   assign out_pix    = out_pix_reg;
   assign out_row    = out_row_reg;
   assign out_col    = out_col_reg;
   assign frame_done = frame_done_reg;

endmodule
